// File: rtl/ro_puf_ctrl.sv
// ----------------------------------------------------------------------------
// ro_puf_ctrl -- ring-oscillator PUF challenge/response controller.
//
// One evaluation: capture a challenge onto the oscillator stage-select and
// bypass lines, let the rings settle, enable them for a fixed window, count
// rising edges on both taps, then compare the counts to produce a response bit.
//
// Parameters
//   WINDOW  measurement window length in CLK cycles (>= 2)
//   SETTLE  cycles between challenge apply and oscillator enable (>= 1)
//   CNT_W   edge-counter width
//
// Ports
//   CLK        system clock, rising edge
//   RST_N      synchronous active-low reset
//   start      request an evaluation (accepted only when idle)
//   challenge  [2:0] stage select, [5:3] stage bypass
//   ro_out1/2  asynchronous oscillator taps
//   ro_sel     stage select to oscillator (held between accepted starts)
//   ro_bx      stage bypass to oscillator (held between accepted starts)
//   ro_en      oscillator enable, high only while measuring
//   busy       high whenever an evaluation is in progress
//   done       one-cycle pulse when resp/tie/cnt1/cnt2 update
//   resp       1 when cnt1 > cnt2
//   tie        1 when cnt1 == cnt2
//   cnt1/cnt2  final edge counts of ro_out1 / ro_out2
// ----------------------------------------------------------------------------
module ro_puf_ctrl #(
    parameter int WINDOW = 1024,
    parameter int SETTLE = 16,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [5:0]       challenge,
    input  logic             ro_out1,
    input  logic             ro_out2,
    output logic [2:0]       ro_sel,
    output logic [2:0]       ro_bx,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic             resp,
    output logic             tie,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;

    // Timer reload values: each state runs until the timer reaches zero.
    localparam logic [TMR_W-1:0] TMR_SETTLE = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] TMR_WINDOW = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0] TMR_DRAIN  = TMR_W'(2);

    // Saturating increment: hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic             inc);
        if (inc && (c != {CNT_W{1'b1}}))
            return c + CNT_W'(1);
        return c;
    endfunction

    logic [2:0]       r_state;
    logic [TMR_W-1:0] r_tmr;
    logic [2:0]       r_sel;
    logic [2:0]       r_bx;
    logic             r_done;
    logic             r_resp;
    logic             r_tie;
    logic [CNT_W-1:0] r_cnt1;
    logic [CNT_W-1:0] r_cnt2;
    logic [CNT_W-1:0] r_c1;
    logic [CNT_W-1:0] r_c2;

    // Bit 0 follows ro_out1, bit 1 follows ro_out2.
    logic [1:0]       r_meta;
    logic [1:0]       r_sync;
    logic [1:0]       r_prev;

    logic [1:0]       w_rise;
    logic             w_counting;
    logic [CNT_W-1:0] w_c1_nxt;
    logic [CNT_W-1:0] w_c2_nxt;

    assign w_rise     = r_sync & ~r_prev;
    // DRAIN keeps counting so edges still in the synchronizer when the
    // oscillators are disabled are not lost.
    assign w_counting = (r_state == S_MEASURE) || (r_state == S_DRAIN);
    assign w_c1_nxt   = sat_inc(r_c1, w_counting & w_rise[0]);
    assign w_c2_nxt   = sat_inc(r_c2, w_counting & w_rise[1]);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_sel   <= '0;
            r_bx    <= '0;
            r_done  <= 1'b0;
            r_resp  <= 1'b0;
            r_tie   <= 1'b0;
            r_cnt1  <= '0;
            r_cnt2  <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_meta  <= '0;
            r_sync  <= '0;
            r_prev  <= '0;
        end else begin
            r_meta <= {ro_out2, ro_out1};
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_done <= 1'b0;
            r_c1   <= w_c1_nxt;
            r_c2   <= w_c2_nxt;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SETTLE;
                        r_tmr   <= TMR_SETTLE;
                        r_sel   <= challenge[2:0];
                        r_bx    <= challenge[5:3];
                        r_c1    <= '0;
                        r_c2    <= '0;
                    end
                end
                S_SETTLE: begin
                    if (r_tmr == '0) begin
                        r_state <= S_MEASURE;
                        r_tmr   <= TMR_WINDOW;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (r_tmr == '0) begin
                        r_state <= S_DRAIN;
                        r_tmr   <= TMR_DRAIN;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_tmr == '0) begin
                        // Results are taken from the next-count values so the
                        // final drain cycle's edge is included; they and done
                        // become visible during the COMPARE cycle.
                        r_state <= S_COMPARE;
                        r_cnt1  <= w_c1_nxt;
                        r_cnt2  <= w_c2_nxt;
                        r_resp  <= (w_c1_nxt > w_c2_nxt);
                        r_tie   <= (w_c1_nxt == w_c2_nxt);
                        r_done  <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_COMPARE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ro_sel = r_sel;
    assign ro_bx  = r_bx;
    assign ro_en  = (r_state == S_MEASURE);
    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign resp   = r_resp;
    assign tie    = r_tie;
    assign cnt1   = r_cnt1;
    assign cnt2   = r_cnt2;

endmodule
